// File: rtl/tmds_channel_encoder_if.sv
// Pixel-side bundle for one TMDS channel: the pixel generator drives the
// video-enable, control bits and colour component; the encoder returns the
// 10-bit symbol bound for the serializer.
interface tmds_channel_encoder_if;
    logic       active_video;
    logic [1:0] ctrl;
    logic [7:0] data;
    logic [9:0] tmds;

    modport master (
        output active_video,
        output ctrl,
        output data,
        input  tmds
    );

    modport slave (
        input  active_video,
        input  ctrl,
        input  data,
        output tmds
    );
endinterface

// File: rtl/tmds_channel_encoder.sv
// Single-channel DVI 8b/10b TMDS encoder.
// Stage 1 builds the transition-minimized word q_m; stage 2 applies DC
// balancing against a running disparity and emits the 10-bit symbol.
// Blanking cycles send one of four control symbols and clear the disparity,
// so every active line segment starts balanced.
module tmds_channel_encoder (
    input  logic                    pixel_clk,
    input  logic                    rst,
    tmds_channel_encoder_if.slave   vid
);

    // Control symbol sent for ctrl = 2'b00; also the reset value of the output.
    localparam logic [9:0] CTRL_SYM_00 = 10'h354;
    localparam logic [9:0] CTRL_SYM_01 = 10'h0AB;
    localparam logic [9:0] CTRL_SYM_10 = 10'h154;
    localparam logic [9:0] CTRL_SYM_11 = 10'h2AB;

    // Number of ones in a byte.
    function automatic logic [3:0] ones8(input logic [7:0] v);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, v[i]};
        end
        return n;
    endfunction

    // Transition-minimized word: XOR or XNOR chain, bit 8 flags XOR mode.
    function automatic logic [8:0] tm_word(input logic [7:0] d, input logic xnor_mode);
        logic [8:0] q;
        q    = 9'd0;
        q[0] = d[0];
        for (int i = 1; i < 8; i++) begin
            if (xnor_mode) begin
                q[i] = ~(q[i-1] ^ d[i]);
            end else begin
                q[i] = q[i-1] ^ d[i];
            end
        end
        q[8] = ~xnor_mode;
        return q;
    endfunction

    // Stage 1 signals and registers
    logic [3:0]        n1d_s;
    logic              use_xnor_s;
    logic [8:0]        qm_s;
    logic [8:0]        qm_r;
    logic              av_r;
    logic [1:0]        ctrl_r;

    // Stage 2 signals and registers
    logic [3:0]        n1q_s;
    logic [3:0]        n0q_s;
    logic signed [5:0] n1q_ext_s;
    logic signed [5:0] n0q_ext_s;
    logic signed [5:0] diff_s;
    logic signed [5:0] two_qm8_s;
    logic signed [5:0] two_nqm8_s;
    logic [9:0]        tmds_nxt_s;
    logic signed [5:0] cnt_nxt_s;
    logic [9:0]        tmds_r;
    logic signed [5:0] cnt_r;

    // Stage 1: choose XOR/XNOR mode from the byte's ones count and build q_m.
    always_comb begin
        n1d_s      = ones8(vid.data);
        use_xnor_s = (n1d_s > 4'd4) || ((n1d_s == 4'd4) && (vid.data[0] == 1'b0));
        qm_s       = tm_word(vid.data, use_xnor_s);
    end

    // Stage 1 pipeline register; enable and control travel with the data.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            qm_r   <= 9'd0;
            av_r   <= 1'b0;
            ctrl_r <= 2'b00;
        end else begin
            qm_r   <= qm_s;
            av_r   <= vid.active_video;
            ctrl_r <= vid.ctrl;
        end
    end

    // Stage 2 operands: ones/zeros of q_m[7:0], widened to signed disparity width.
    always_comb begin
        n1q_s      = ones8(qm_r[7:0]);
        n0q_s      = 4'd8 - n1q_s;
        n1q_ext_s  = $signed({2'b00, n1q_s});
        n0q_ext_s  = $signed({2'b00, n0q_s});
        diff_s     = n1q_ext_s - n0q_ext_s;
        two_qm8_s  = $signed({4'b0000, qm_r[8], 1'b0});
        two_nqm8_s = $signed({4'b0000, ~qm_r[8], 1'b0});
    end

    // Stage 2: DC balancing for active pixels, control symbols while blanked.
    always_comb begin
        tmds_nxt_s = CTRL_SYM_00;
        cnt_nxt_s  = 6'sd0;
        if (av_r) begin
            if ((cnt_r == 6'sd0) || (n1q_s == n0q_s)) begin
                // No preference: invert the payload only in XNOR mode.
                tmds_nxt_s = {~qm_r[8], qm_r[8], (qm_r[8] ? qm_r[7:0] : ~qm_r[7:0])};
                if (qm_r[8]) begin
                    cnt_nxt_s = cnt_r + diff_s;
                end else begin
                    cnt_nxt_s = cnt_r - diff_s;
                end
            end else if (((cnt_r > 6'sd0) && (n1q_s > n0q_s)) ||
                         ((cnt_r < 6'sd0) && (n0q_s > n1q_s))) begin
                // Word would worsen the imbalance: send it inverted.
                tmds_nxt_s = {1'b1, qm_r[8], ~qm_r[7:0]};
                cnt_nxt_s  = cnt_r + two_qm8_s - diff_s;
            end else begin
                tmds_nxt_s = {1'b0, qm_r[8], qm_r[7:0]};
                cnt_nxt_s  = cnt_r + diff_s - two_nqm8_s;
            end
        end else begin
            case (ctrl_r)
                2'b00:   tmds_nxt_s = CTRL_SYM_00;
                2'b01:   tmds_nxt_s = CTRL_SYM_01;
                2'b10:   tmds_nxt_s = CTRL_SYM_10;
                2'b11:   tmds_nxt_s = CTRL_SYM_11;
                default: tmds_nxt_s = CTRL_SYM_00;
            endcase
            cnt_nxt_s = 6'sd0;
        end
    end

    // Stage 2 output register and running disparity.
    always_ff @(posedge pixel_clk or posedge rst) begin
        if (rst) begin
            tmds_r <= CTRL_SYM_00;
            cnt_r  <= 6'sd0;
        end else begin
            tmds_r <= tmds_nxt_s;
            cnt_r  <= cnt_nxt_s;
        end
    end

    assign vid.tmds = tmds_r;

endmodule
